// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Holds the state encoding, field widths, the default memory timeout and the load-use hazard test.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_W          = 8;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned STALL_W         = 16;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic             ex_memread,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt
    );
        return ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline-side signal bundle for the stall controller; slave is the controller, master the pipeline.
// Purely combinational wiring, no latency; no flow control of its own.
interface pipeline_stall_ctrl_if;
    import pipeline_stall_ctrl_pkg::*;

    logic               start_i;
    logic [REG_W-1:0]   IFID_rs_i;
    logic [REG_W-1:0]   IFID_rt_i;
    logic [REG_W-1:0]   IDEX_rt_i;
    logic               IDEX_memread_i;
    logic               branch_taken_i;
    logic               jump_i;
    logic               dmem_req_i;
    logic               dmem_ack_i;

    logic               pc_write_o;
    logic               ifid_write_o;
    logic               ifid_flush_o;
    logic               bubble_o;
    logic               freeze_o;
    logic               dmem_start_o;
    logic               err_o;
    logic [STALL_W-1:0] stall_cycles_o;

    modport master (
        output start_i, IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_memread_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, freeze_o,
               dmem_start_o, err_o, stall_cycles_o
    );

    modport slave (
        input  start_i, IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_memread_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, freeze_o,
               dmem_start_o, err_o, stall_cycles_o
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
// One-cycle update latency; no backpressure, enable is sampled every cycle.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles, branch/jump flushes and data-memory freezes.
// Controls are combinational (0-cycle) from state and inputs; a memory access freezes the pipe until ack or TIMEOUT.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_stall_ctrl_if.slave bus
);

    // Last wait cycle index: the counter reaching TIMEOUT happens on this cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic              hazard;
    logic              unfrozen;
    logic              pc_write, ifid_write, ifid_flush, bubble, freeze, dmem_start;
    logic              stall_en;

    assign hazard = load_use_hazard(bus.IDEX_memread_i, bus.IDEX_rt_i,
                                    bus.IFID_rs_i, bus.IFID_rt_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) state <= RUN;
                end
                RUN: begin
                    if (bus.dmem_req_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ack_i) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERROR;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Freeze dominates, then load-use bubble, then branch/jump flush.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        bubble     = 1'b1;
        freeze     = 1'b1;
        dmem_start = 1'b0;
        unfrozen   = 1'b0;
        case (state)
            RUN: begin
                if (bus.dmem_req_i) begin
                    bubble     = 1'b0;
                    dmem_start = 1'b1;
                end else begin
                    unfrozen = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack_i) unfrozen = 1'b1;
                else                bubble   = 1'b0;
            end
            default: ;
        endcase
        if (unfrozen) begin
            freeze = 1'b0;
            if (!hazard) begin
                bubble     = 1'b0;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                ifid_flush = bus.branch_taken_i | bus.jump_i;
            end
        end
    end

    assign stall_en = ((state == RUN) || (state == MEM_WAIT)) && (freeze || bubble);

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_en),
        .cnt   (bus.stall_cycles_o)
    );

    assign bus.pc_write_o   = pc_write;
    assign bus.ifid_write_o = ifid_write;
    assign bus.ifid_flush_o = ifid_flush;
    assign bus.bubble_o     = bubble;
    assign bus.freeze_o     = freeze;
    assign bus.dmem_start_o = dmem_start;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int TO = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: controller started, memory access outstanding, failed cycles waited, sticky error, stall count.
    bit m_started, m_busy, m_err;
    int m_waited, m_stalls;
    int base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] obs_ctl();
        return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.bubble_o,
                bus.freeze_o, bus.dmem_start_o, bus.err_o};
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, bubble, freeze, dmem_start, err}.
    function automatic logic [6:0] model_ctl();
        bit hz;
        bit ctrl_xfer;
        hz = bus.IDEX_memread_i && (bus.IDEX_rt_i != 0) &&
             (bus.IDEX_rt_i == bus.IFID_rs_i || bus.IDEX_rt_i == bus.IFID_rt_i);
        ctrl_xfer = bus.branch_taken_i || bus.jump_i;
        if (!m_started || m_err)            return {6'b000110, m_err};
        if (!m_busy && bus.dmem_req_i)      return 7'b0000110;
        if (m_busy && !bus.dmem_ack_i)      return 7'b0000100;
        if (hz)                             return 7'b0001000;
        return {2'b11, ctrl_xfer, 4'b0000};
    endfunction

    task automatic model_step(input logic [6:0] ctl);
        if (m_started && !m_err && (ctl[3] || ctl[2]) && m_stalls < 65535) m_stalls++;
        if (!m_started) begin
            m_started = bus.start_i;
        end else if (!m_err) begin
            if (!m_busy) begin
                if (bus.dmem_req_i) begin
                    m_busy   = 1'b1;
                    m_waited = 0;
                end
            end else if (bus.dmem_ack_i) begin
                m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TO) m_err = 1'b1;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic advance(input string tag);
        logic [6:0] exp;
        exp = model_ctl();
        check({tag, "/ctl"}, 32'(obs_ctl()), 32'(exp));
        check({tag, "/stall"}, 32'(bus.stall_cycles_o), 32'(m_stalls));
        model_step(exp);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic cycle(input string tag);
        settle();
        advance(tag);
    endtask

    task automatic clear_inputs();
        bus.start_i        = 1'b0;
        bus.IFID_rs_i      = '0;
        bus.IFID_rt_i      = '0;
        bus.IDEX_rt_i      = '0;
        bus.IDEX_memread_i = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.jump_i         = 1'b0;
        bus.dmem_req_i     = 1'b0;
        bus.dmem_ack_i     = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks the idle outputs appear without a clock edge.
    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        #1;
        m_started = 0; m_busy = 0; m_err = 0; m_waited = 0; m_stalls = 0;
        check({tag, "/rst_ctl"}, 32'(obs_ctl()), 32'(7'b0001100));
        check({tag, "/rst_stall"}, 32'(bus.stall_cycles_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic start_run();
        bus.start_i = 1'b1;
        cycle("start");
        bus.start_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset("por");

        // Start at cycle 2, running from cycle 3.
        cycle("c0");
        cycle("c1");
        bus.start_i = 1'b1;
        cycle("c2");
        bus.start_i = 1'b0;
        settle();
        check("c3_pc_write", 32'(bus.pc_write_o), 32'd1);
        check("c3_stall", 32'(bus.stall_cycles_o), 32'd0);
        advance("c3");
        cycle("c4");

        // Load-use hazard gives a single bubble.
        bus.IDEX_memread_i = 1'b1; bus.IDEX_rt_i = 5'd5; bus.IFID_rs_i = 5'd5;
        settle();
        check("hz_bubble", 32'(bus.bubble_o), 32'd1);
        check("hz_pc_write", 32'(bus.pc_write_o), 32'd0);
        advance("hz");
        bus.IDEX_memread_i = 1'b0;
        settle();
        check("hz_after_pc", 32'(bus.pc_write_o), 32'd1);
        advance("hz_after");
        bus.IDEX_memread_i = 1'b1; bus.IDEX_rt_i = 5'd0; bus.IFID_rs_i = 5'd0;
        settle();
        check("r0_bubble", 32'(bus.bubble_o), 32'd0);
        advance("r0");

        // Hazard beats branch; the flush follows once the hazard clears.
        bus.IDEX_rt_i = 5'd7; bus.IFID_rt_i = 5'd7; bus.branch_taken_i = 1'b1;
        settle();
        check("hzbr_bubble", 32'(bus.bubble_o), 32'd1);
        check("hzbr_flush", 32'(bus.ifid_flush_o), 32'd0);
        advance("hzbr");
        bus.IDEX_memread_i = 1'b0;
        settle();
        check("br_flush", 32'(bus.ifid_flush_o), 32'd1);
        advance("br");
        bus.branch_taken_i = 1'b0;
        bus.jump_i = 1'b1;
        cycle("jmp");
        clear_inputs();

        // Memory access acknowledged after four frozen cycles.
        base = m_stalls;
        bus.dmem_req_i = 1'b1;
        settle();
        check("mem_start", 32'(bus.dmem_start_o), 32'd1);
        advance("mem_req");
        bus.dmem_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mem_wait_start", 32'(bus.dmem_start_o), 32'd0);
            check("mem_wait_freeze", 32'(bus.freeze_o), 32'd1);
            advance("mem_wait");
        end
        bus.dmem_ack_i = 1'b1;
        settle();
        check("mem_ack_freeze", 32'(bus.freeze_o), 32'd0);
        advance("mem_ack");
        bus.dmem_ack_i = 1'b0;
        settle();
        check("mem_stall_delta", 32'(bus.stall_cycles_o), 32'(base + 4));
        advance("mem_done");

        // Ack on the last permitted wait cycle still completes the access.
        bus.dmem_req_i = 1'b1;
        cycle("edge_req");
        bus.dmem_req_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) cycle("edge_wait");
        bus.dmem_ack_i = 1'b1;
        cycle("edge_ack");
        bus.dmem_ack_i = 1'b0;
        settle();
        check("edge_err", 32'(bus.err_o), 32'd0);
        check("edge_pc_write", 32'(bus.pc_write_o), 32'd1);
        advance("edge_run");

        // No ack: error after TO wait cycles, sticky and deaf to a late ack.
        bus.dmem_req_i = 1'b1;
        cycle("to_req");
        bus.dmem_req_i = 1'b0;
        for (int i = 0; i < TO; i++) cycle("to_wait");
        settle();
        check("to_err", 32'(bus.err_o), 32'd1);
        advance("to_err_cyc");
        bus.dmem_ack_i = 1'b1;
        cycle("to_late_ack");
        bus.dmem_ack_i = 1'b0;
        settle();
        check("to_sticky", 32'(bus.err_o), 32'd1);
        check("to_freeze", 32'(bus.freeze_o), 32'd1);
        advance("to_hold");
        do_reset("to_rst");
        settle();
        check("to_rst_err", 32'(bus.err_o), 32'd0);
        advance("to_rst_idle");

        // Reset abandons an access; the ack that follows is ignored.
        start_run();
        bus.dmem_req_i = 1'b1;
        cycle("ab_req");
        bus.dmem_req_i = 1'b0;
        cycle("ab_wait");
        cycle("ab_wait");
        do_reset("ab_rst");
        bus.dmem_ack_i = 1'b1;
        cycle("ab_ack");
        bus.dmem_ack_i = 1'b0;
        settle();
        check("ab_idle", 32'(obs_ctl()), 32'(7'b0001100));
        advance("ab_idle_cyc");

        // Random traffic with occasional resets.
        start_run();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_rst");
                bus.start_i = 1'b1;
            end else begin
                bus.start_i = ($urandom_range(0, 3) == 0);
            end
            bus.IFID_rs_i      = 5'($urandom_range(0, 3));
            bus.IFID_rt_i      = 5'($urandom_range(0, 3));
            bus.IDEX_rt_i      = 5'($urandom_range(0, 3));
            bus.IDEX_memread_i = ($urandom_range(0, 1) == 1);
            bus.branch_taken_i = ($urandom_range(0, 3) == 0);
            bus.jump_i         = ($urandom_range(0, 7) == 0);
            bus.dmem_req_i     = ($urandom_range(0, 3) == 0);
            bus.dmem_ack_i     = ($urandom_range(0, 5) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
